alarm_ringer: RTL

Downstream consumer of the watch control logic's alerm_equal flag. It turns that level into a timed buzzer pattern with snooze and stop handling, and drives the buzzer pin and status LEDs. It sits beside the bin2bcd/trans_seg display path in the digital watch top level. Its minute_set/hour_set-style key pulses come from pulse_maker instances.

---
 rtl/watch_pkg.sv | 18 +
 rtl/tick_gen.sv | 31 +++
 rtl/alarm_ringer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the digital watch alarm path.
package watch_pkg;

    // Alarm ringer states.
    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE,
        DONE
    } state_t;

    // Width of the snooze counter (up to three snoozes per event).
    localparam int SNOOZE_CNT_W = 2;

    // 4 Hz tick from the 50 MHz board clock.
    localparam int DEFAULT_TICK_DIV = 12_500_000;

endpackage : watch_pkg

// File: rtl/tick_gen.sv
// Free-running prescaler that emits a one-cycle tick every DIV clocks.
module tick_gen
    import watch_pkg::*;
#(
    parameter int DIV = DEFAULT_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    // Tick fires while the counter sits at its terminal value.
    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // Count 0..DIV-1 forever; nothing but reset restarts it.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule : tick_gen

// File: rtl/alarm_ringer.sv
// Turns the alarm-match level into a timed buzzer pattern with snooze/stop.
module alarm_ringer
    import watch_pkg::*;
#(
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int RING_TICKS   = 240,
    parameter int SNOOZE_TICKS = 1200,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alerm_equal,
    input  logic                    alerm_switch,
    input  logic                    stop,
    input  logic                    snooze,
    output logic                    buzzer,
    output logic                    ringing,
    output logic                    snoozing,
    output logic [SNOOZE_CNT_W-1:0] snooze_count
);

    localparam int TIMER_MAX = (RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0]      RING_LAST   = TIMER_W'(RING_TICKS - 1);
    localparam logic [TIMER_W-1:0]      SNOOZE_LAST = TIMER_W'(SNOOZE_TICKS - 1);
    localparam logic [SNOOZE_CNT_W-1:0] SNOOZE_LIM  = SNOOZE_CNT_W'(MAX_SNOOZE);

    logic                    tick;
    state_t                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic                    phase_q, phase_d;
    logic [SNOOZE_CNT_W-1:0] count_d;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Next-state, timer, phase and snooze-count decisions.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        phase_d = phase_q;
        count_d = snooze_count;

        unique case (state_q)
            IDLE: begin
                if (alerm_switch && alerm_equal) begin
                    state_d = RING;
                    phase_d = 1'b1;
                end
            end
            RING: begin
                if (!alerm_switch) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (stop) begin
                    state_d = DONE;
                end else if (snooze) begin
                    if (snooze_count < SNOOZE_LIM) begin
                        state_d = SNOOZE;
                        count_d = snooze_count + 1'b1;
                    end else begin
                        // Out of snoozes: behaves like stop.
                        state_d = DONE;
                    end
                end else if (tick) begin
                    if (timer_q == RING_LAST) begin
                        state_d = DONE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        phase_d = ~phase_q;
                    end
                end
            end
            SNOOZE: begin
                if (!alerm_switch) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (stop) begin
                    state_d = DONE;
                end else if (tick) begin
                    if (timer_q == SNOOZE_LAST) begin
                        state_d = RING;
                        phase_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // Lockout until the matching minute ends or the alarm is disabled.
                if (!alerm_equal || !alerm_switch) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase

        // Each interval starts counting from zero on entry.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // State, timer and phase registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
        end
    end

    // Outputs registered from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buzzer       <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= '0;
        end else begin
            buzzer       <= (state_d == RING) && phase_d;
            ringing      <= (state_d == RING);
            snoozing     <= (state_d == SNOOZE);
            snooze_count <= count_d;
        end
    end

endmodule : alarm_ringer
